// File: rtl/cfg_mem_pkg.sv
// Shared types and helpers for the shadowed tile configuration memory.
// Holds the commit FSM state encoding and the frame-count calculation.
package cfg_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        COMMIT
    } cfgStateT;

    // Number of frames needed to cover cfg_bits configuration bits (ceiling division).
    function automatic int cfg_no_frames(input int cfg_bits, input int frame_bits);
        return (cfg_bits + frame_bits - 1) / frame_bits;
    endfunction

endpackage

// File: rtl/cfg_frame_strobe_edge.sv
// Registers the level frame strobes and reports rising edges in this cycle.
// The bench of strobes is one-hot by contract; a multi-hot rise is flagged instead of acted on.
module cfg_frame_strobe_edge #(
    parameter int Width = 20
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic [Width-1:0] FrameStrobe,
    output logic [Width-1:0] edgeHot,
    output logic             edgeValid,
    output logic             edgeMulti
);

    logic [Width-1:0] strobeReg;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            strobeReg <= '0;
        end else begin
            strobeReg <= FrameStrobe;
        end
    end

    // Clearing the lowest set bit leaves something behind only when two or more edges rose together.
    assign edgeHot   = FrameStrobe & ~strobeReg;
    assign edgeMulti = |(edgeHot & (edgeHot - Width'(1)));
    assign edgeValid = (|edgeHot) & ~edgeMulti;

endmodule

// File: rtl/config_mem_shadow_param.sv
// Shadowed tile configuration memory: frames load into a shadow store and are copied
// to the live ConfigBits in a single commit cycle, with completeness tracking and readback.
module config_mem_shadow_param
    import cfg_mem_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 48
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic [FrameBitsPerRow-1:0]         FrameData,
    input  logic [MaxFramesPerCol-1:0]         FrameStrobe,
    input  logic                               Commit,
    input  logic                               ErrClear,
    input  logic [$clog2(MaxFramesPerCol)-1:0] RdFrame,
    output logic [FrameBitsPerRow-1:0]         RdData,
    output logic [NoConfigBits-1:0]            ConfigBits,
    output logic [NoConfigBits-1:0]            ConfigBits_N,
    output logic                               Loaded,
    output logic                               Err
);

    localparam int NoFrames = cfg_no_frames(NoConfigBits, FrameBitsPerRow);

    logic [FrameBitsPerRow-1:0] shadowReg [NoFrames];
    logic [FrameBitsPerRow-1:0] liveReg   [NoFrames];
    logic [FrameBitsPerRow-1:0] keepBits  [NoFrames];
    logic [NoFrames-1:0]        maskReg;
    logic [NoFrames-1:0]        pendHotReg;
    logic [FrameBitsPerRow-1:0] pendDataReg;
    logic [FrameBitsPerRow-1:0] rdDataReg, rdMux;
    logic                       errReg;
    cfgStateT                   stateReg, stateNext;

    logic [MaxFramesPerCol-1:0] edgeHot, inRange, validHot;
    logic                       edgeValid, edgeMulti;
    logic [NoFrames-1:0]        wrHot;
    logic                       anyWrite, commitGo, commitBad, deferWrite;

    cfg_frame_strobe_edge #(.Width(MaxFramesPerCol)) strobeEdge (
        .CLK        (CLK),
        .resetn     (resetn),
        .FrameStrobe(FrameStrobe),
        .edgeHot    (edgeHot),
        .edgeValid  (edgeValid),
        .edgeMulti  (edgeMulti)
    );

    for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : gInRange
        assign inRange[gi] = (gi < NoFrames) ? 1'b1 : 1'b0;
    end

    // The last frame only carries its top bits; the remainder is forced to 0 when stored.
    for (genvar gi = 0; gi < NoFrames; gi++) begin : gFrame
        localparam int CutRaw = FrameBitsPerRow * (gi + 1) - NoConfigBits;
        localparam int Cut    = (CutRaw > 0) ? CutRaw : 0;
        assign keepBits[gi] = {FrameBitsPerRow{1'b1}} << Cut;
        for (genvar gj = 0; gj < FrameBitsPerRow; gj++) begin : gBit
            localparam int Idx = NoConfigBits - FrameBitsPerRow * (gi + 1) + gj;
            if (Idx >= 0) begin : gMap
                assign ConfigBits[Idx] = liveReg[gi][gj];
            end
        end
    end

    assign validHot   = edgeHot & inRange & {MaxFramesPerCol{edgeValid}};
    assign wrHot      = validHot[NoFrames-1:0];
    assign anyWrite   = |validHot;
    assign Loaded     = &maskReg;
    assign commitGo   = (stateReg == LOADING) && Commit && Loaded;
    assign commitBad  = (stateReg == LOADING) && Commit && !Loaded;
    // A write arriving with an accepted commit is parked until the copy has taken the old shadow.
    assign deferWrite = commitGo && anyWrite;

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE:    if (anyWrite) stateNext = LOADING;
            LOADING: if (commitGo) stateNext = COMMIT;
            COMMIT:  stateNext = (anyWrite || (|pendHotReg)) ? LOADING : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        rdMux = '0;
        for (int f = 0; f < NoFrames; f++) begin
            if (int'(RdFrame) == f) rdMux = liveReg[f];
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            stateReg    <= IDLE;
            maskReg     <= '0;
            pendHotReg  <= '0;
            pendDataReg <= '0;
            errReg      <= 1'b0;
            rdDataReg   <= '0;
            for (int f = 0; f < NoFrames; f++) begin
                shadowReg[f] <= '0;
                liveReg[f]   <= '0;
            end
        end else begin
            stateReg    <= stateNext;
            rdDataReg   <= rdMux;
            pendHotReg  <= deferWrite ? wrHot : '0;
            pendDataReg <= FrameData;
            errReg      <= (edgeMulti || commitBad) ? 1'b1 : (ErrClear ? 1'b0 : errReg);
            maskReg     <= ((stateReg == COMMIT) ? '0 : maskReg) | pendHotReg
                           | (deferWrite ? '0 : wrHot);
            for (int f = 0; f < NoFrames; f++) begin
                if (stateReg == COMMIT) liveReg[f] <= shadowReg[f];
                if (wrHot[f] && !deferWrite) shadowReg[f] <= FrameData & keepBits[f];
                else if (pendHotReg[f])      shadowReg[f] <= pendDataReg & keepBits[f];
            end
        end
    end

    assign RdData       = rdDataReg;
    assign Err          = errReg;
    assign ConfigBits_N = ~ConfigBits;

endmodule
